bpt_update_sched: RTL and testbench

Resolution-side update scheduler for the tournament branch predictor table. Collects resolved-branch updates from two resolution sources, such as the scalar branch unit and the tensor-core loop-branch unit, into a small FIFO. Arbitrates between the two sources round-robin and drains one update per cycle onto the predictor's `pc_res` / `taken_res` / `enable_res` inputs. Also provides a quiesce sequence: stop intake, drain everything, then signal done, used before predictor snapshot or context switch.

---
 rtl/bpt_update_sched_if.sv | 31 +++
 rtl/bpt_update_sched.sv | 114 +++++++++++
 tb/tb_bpt_update_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpt_update_sched_if.sv
// Request/drain bundle for bpt_update_sched: two resolution sources in, one predictor update out.
// slave is the scheduler's view; master is the driver's view.
interface bpt_update_sched_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [1:0]            req_valid;
  logic [1:0][31:0]      req_pc;
  logic [1:0][1:0]       req_taken;
  logic [1:0]            req_ready;
  logic                  hold;
  logic                  quiesce_req;
  logic                  quiesce_done;
  logic [31:0]           pc_res;
  logic [1:0]            taken_res;
  logic                  enable_res;
  logic [CntW-1:0]       count;
  logic                  full;
  logic                  empty;

  modport master (
    output req_valid, req_pc, req_taken, hold, quiesce_req,
    input  req_ready, quiesce_done, pc_res, taken_res, enable_res, count, full, empty
  );

  modport slave (
    input  req_valid, req_pc, req_taken, hold, quiesce_req,
    output req_ready, quiesce_done, pc_res, taken_res, enable_res, count, full, empty
  );
endinterface

// File: rtl/bpt_update_sched.sv
// Round-robin update FIFO feeding the tournament predictor, one update per cycle,
// with a quiesce sequence (close intake, drain, pulse done).
module bpt_update_sched #(
  parameter int unsigned DEPTH = 4
) (
  input logic               CLK,
  input logic               RST,
  bpt_update_sched_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StActive, StQuiesce, StDone} state_e;

  state_e            state_q;
  logic [33:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              last_grant_q;
  logic              full_q, empty_q;
  logic [31:0]       pc_res_q;
  logic [1:0]        taken_res_q;
  logic              enable_res_q;
  logic              quiesce_done_q;

  logic              intake_ok;
  logic [1:0]        grant;
  logic              push, pop, push_src;
  logic [33:0]       push_entry;

  assign intake_ok = ((state_q == StIdle) || (state_q == StActive)) && !full_q;

  // Ties go to the source that did not win the previous transfer.
  always_comb begin
    grant = 2'b00;
    if (intake_ok) begin
      unique case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign push       = |grant;
  assign push_src   = grant[1];
  assign push_entry = {bus.req_pc[push_src], bus.req_taken[push_src]};
  // Pop decision uses pre-push occupancy, so a fresh entry waits one edge.
  assign pop        = !bus.hold && !empty_q;
  assign count_d    = count_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_grant_q   <= 1'b1;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      pc_res_q       <= '0;
      taken_res_q    <= 2'b00;
      enable_res_q   <= 1'b0;
      quiesce_done_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q     <= wr_ptr_q + PtrW'(1);
        last_grant_q <= push_src;
      end
      if (pop) begin
        {pc_res_q, taken_res_q} <= mem_q[rd_ptr_q];
        rd_ptr_q                <= rd_ptr_q + PtrW'(1);
      end
      enable_res_q   <= pop;
      count_q        <= count_d;
      full_q         <= (count_d == CntW'(DEPTH));
      empty_q        <= (count_d == '0);
      quiesce_done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.quiesce_req) state_q <= StQuiesce;
          else if (push)       state_q <= StActive;
        end
        StActive: begin
          if (bus.quiesce_req)                state_q <= StQuiesce;
          else if (count_d == '0 && !push)    state_q <= StIdle;
        end
        StQuiesce: begin
          if (count_d == '0) begin
            state_q        <= StDone;
            quiesce_done_q <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready    = grant;
  assign bus.pc_res       = pc_res_q;
  assign bus.taken_res    = taken_res_q;
  assign bus.enable_res   = enable_res_q;
  assign bus.quiesce_done = quiesce_done_q;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
endmodule

// File: tb/tb_bpt_update_sched.sv
// Bench for bpt_update_sched: scenario tasks plus a queue-based lockstep model of the
// FIFO, arbitration and quiesce protocol, checked every cycle.
module tb_bpt_update_sched;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpt_update_sched_if #(.DEPTH(DEPTH)) bus ();
  bpt_update_sched #(.DEPTH(DEPTH)) dut (.CLK(clk), .RST(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [33:0] mq[$];
  bit          m_last;
  bit          m_open, m_quiescing, m_done_phase;
  logic [31:0] m_pc;
  logic [1:0]  m_taken;
  bit          m_en, m_done;

  logic [1:0]  obs_ready;
  logic [31:0] dut_drained[$];

  task automatic model_reset();
    mq.delete();
    m_last = 1'b1; m_open = 1'b1; m_quiescing = 1'b0; m_done_phase = 1'b0;
    m_pc = '0; m_taken = 2'b00; m_en = 1'b0; m_done = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00; bus.req_pc = '0; bus.req_taken = '0;
    bus.hold = 1'b0; bus.quiesce_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  // One clock: check grant pre-edge, advance the model, check registered outputs post-edge.
  task automatic step();
    logic [1:0]  exp_ready;
    logic [33:0] head;
    bit          do_pop, q_req;
    int          src;
    #1;
    exp_ready = 2'b00;
    if (m_open && mq.size() < DEPTH && bus.req_valid != 2'b00) begin
      if (bus.req_valid == 2'b11) src = m_last ? 0 : 1;
      else                        src = bus.req_valid[1] ? 1 : 0;
      exp_ready = 2'(1 << src);
    end
    obs_ready = bus.req_ready;
    vectors++;
    if (bus.req_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL req_ready: got %b want %b at %0t", bus.req_ready, exp_ready, $time);
    end
    q_req  = bus.quiesce_req;
    do_pop = !bus.hold && mq.size() > 0;
    m_en   = do_pop;
    if (do_pop) begin
      head = mq.pop_front();
      m_pc = head[33:2]; m_taken = head[1:0];
    end
    if (exp_ready != 2'b00) begin
      src = exp_ready[1] ? 1 : 0;
      mq.push_back({bus.req_pc[src], bus.req_taken[src]});
      m_last = (src == 1);
    end
    m_done = 1'b0;
    if (m_done_phase) begin
      m_done_phase = 1'b0; m_open = 1'b1;
    end else if (m_quiescing) begin
      if (mq.size() == 0) begin m_done = 1'b1; m_done_phase = 1'b1; m_quiescing = 1'b0; end
    end else if (q_req) begin
      m_quiescing = 1'b1; m_open = 1'b0;
    end
    @(posedge clk); #1;
    if (bus.enable_res === 1'b1) dut_drained.push_back(bus.pc_res);
    vectors++;
    if (bus.enable_res !== m_en) begin
      miscompares++;
      $display("FAIL enable_res: got %b want %b at %0t", bus.enable_res, m_en, $time);
    end
    vectors++;
    if (bus.pc_res !== m_pc || bus.taken_res !== m_taken) begin
      miscompares++;
      $display("FAIL pc_res/taken_res: got %h/%b want %h/%b at %0t",
               bus.pc_res, bus.taken_res, m_pc, m_taken, $time);
    end
    vectors++;
    if (bus.count !== CW'(mq.size()) || bus.full !== (mq.size() == DEPTH) ||
        bus.empty !== (mq.size() == 0)) begin
      miscompares++;
      $display("FAIL occupancy: got count=%0d full=%b empty=%b want count=%0d at %0t",
               bus.count, bus.full, bus.empty, mq.size(), $time);
    end
    vectors++;
    if (bus.quiesce_done !== m_done) begin
      miscompares++;
      $display("FAIL quiesce_done: got %b want %b at %0t", bus.quiesce_done, m_done, $time);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    #1;
    vectors++;
    if (bus.count !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_occupancy: got count=%0d empty=%b full=%b want 0/1/0",
               bus.count, bus.empty, bus.full);
    end
    vectors++;
    if (bus.pc_res !== 32'h0 || bus.taken_res !== 2'b00 || bus.enable_res !== 1'b0 ||
        bus.quiesce_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pc=%h taken=%b en=%b done=%b want 0/00/0/0",
               bus.pc_res, bus.taken_res, bus.enable_res, bus.quiesce_done);
    end
  endtask

  task automatic test_single();
    idle_inputs();
    do_reset();
    bus.req_valid = 2'b01; bus.req_pc[0] = 32'h0000_1040; bus.req_taken[0] = 2'b10;
    step();
    vectors++;
    if (obs_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 01", obs_ready);
    end
    bus.req_valid = 2'b00;
    step();
    vectors++;
    if (bus.enable_res !== 1'b1 || bus.pc_res !== 32'h1040 || bus.taken_res !== 2'b10 ||
        bus.count !== '0) begin
      miscompares++;
      $display("FAIL single_strobe: got en=%b pc=%h taken=%b count=%0d want 1/1040/10/0",
               bus.enable_res, bus.pc_res, bus.taken_res, bus.count);
    end
    step();
    vectors++;
    if (bus.enable_res !== 1'b0) begin
      miscompares++;
      $display("FAIL single_one_cycle: got en=%b want 0", bus.enable_res);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  order [4];
    logic [31:0] exp_pc [4];
    int n0, n1;
    idle_inputs();
    do_reset();
    n0 = 0; n1 = 0;
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h200; exp_pc[2] = 32'h104; exp_pc[3] = 32'h204;
    dut_drained.delete();
    for (int c = 0; c < 4; c++) begin
      bus.req_valid = 2'b11;
      bus.req_pc[0] = 32'h100 + 32'(4 * n0);
      bus.req_pc[1] = 32'h200 + 32'(4 * n1);
      step();
      order[c] = obs_ready;
      if (obs_ready[0]) n0++;
      if (obs_ready[1]) n1++;
    end
    bus.req_valid = 2'b00;
    for (int c = 0; c < 4; c++) step();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (order[c] !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got %b want %b", c, order[c],
                 (c % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    vectors++;
    if (dut_drained.size() != 4) begin
      miscompares++;
      $display("FAIL rr_drain_count: got %0d want 4", dut_drained.size());
    end else begin
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (dut_drained[c] !== exp_pc[c]) begin
          miscompares++;
          $display("FAIL rr_drain[%0d]: got %h want %h", c, dut_drained[c], exp_pc[c]);
        end
      end
    end
  endtask

  task automatic test_full();
    int k;
    idle_inputs();
    do_reset();
    dut_drained.delete();
    k = 0;
    bus.hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = 2'b10; bus.req_pc[1] = 32'h300 + 32'(4 * k);
      step();
      if (obs_ready[1]) k++;
    end
    #1;
    vectors++;
    if (bus.full !== 1'b1 || bus.req_ready !== 2'b00 || k != 4) begin
      miscompares++;
      $display("FAIL full_backpressure: got full=%b ready=%b pushes=%0d want 1/00/4",
               bus.full, bus.req_ready, k);
    end
    bus.hold = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = (k < 5) ? 2'b10 : 2'b00;
      bus.req_pc[1] = 32'h300 + 32'(4 * k);
      step();
      if (obs_ready[1]) k++;
    end
    vectors++;
    if (dut_drained.size() != 5) begin
      miscompares++;
      $display("FAIL full_drain_count: got %0d want 5", dut_drained.size());
    end else begin
      for (int c = 0; c < 5; c++) begin
        vectors++;
        if (dut_drained[c] !== 32'h300 + 32'(4 * c)) begin
          miscompares++;
          $display("FAIL full_drain[%0d]: got %h want %h", c, dut_drained[c],
                   32'h300 + 32'(4 * c));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] sent[$];
    logic [31:0] pc;
    int cyc, max_count;
    idle_inputs();
    do_reset();
    dut_drained.delete();
    cyc = 0; max_count = 0;
    pc = $urandom;
    while ((sent.size() < 10 || dut_drained.size() < 10) && cyc < 80) begin
      bus.hold = ((cyc / 3) % 2) == 1;
      if (sent.size() < 10) begin
        bus.req_valid = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        bus.req_pc[0] = pc; bus.req_pc[1] = pc;
        bus.req_taken[0] = 2'($urandom); bus.req_taken[1] = 2'($urandom);
      end else begin
        bus.req_valid = 2'b00;
      end
      step();
      if (obs_ready != 2'b00) begin sent.push_back(pc); pc = $urandom; end
      if (int'(bus.count) > max_count) max_count = int'(bus.count);
      cyc++;
    end
    vectors++;
    if (cyc >= 80 || dut_drained.size() != 10) begin
      miscompares++;
      $display("FAIL wrap_timeout: got %0d drained want 10", dut_drained.size());
    end else begin
      for (int c = 0; c < 10; c++) begin
        vectors++;
        if (dut_drained[c] !== sent[c]) begin
          miscompares++;
          $display("FAIL wrap_order[%0d]: got %h want %h", c, dut_drained[c], sent[c]);
        end
      end
    end
    vectors++;
    if (max_count > DEPTH) begin
      miscompares++;
      $display("FAIL wrap_max_count: got %0d want <= %0d", max_count, DEPTH);
    end
  endtask

  task automatic test_quiesce();
    int strobes, dones;
    idle_inputs();
    do_reset();
    bus.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 2'b01; bus.req_pc[0] = 32'h500 + 32'(4 * c);
      step();
    end
    bus.req_valid = 2'b00; bus.hold = 1'b0; bus.quiesce_req = 1'b1;
    strobes = 0; dones = 0;
    step();
    strobes += int'(bus.enable_res);
    bus.quiesce_req = 1'b0;
    bus.req_valid = 2'b01; bus.req_pc[0] = 32'h600;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (obs_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL quiesce_intake_closed[%0d]: got %b want 00", c, obs_ready);
      end
      strobes += int'(bus.enable_res);
      dones   += int'(bus.quiesce_done);
    end
    vectors++;
    if (strobes != 3 || dones != 1) begin
      miscompares++;
      $display("FAIL quiesce_drain: got strobes=%0d dones=%0d want 3/1", strobes, dones);
    end
    step();
    vectors++;
    if (obs_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL quiesce_resume: got %b want 01", obs_ready);
    end
    bus.req_valid = 2'b00;
    step();
    bus.quiesce_req = 1'b1;
    step();
    bus.quiesce_req = 1'b0;
    vectors++;
    if (bus.quiesce_done !== 1'b0) begin
      miscompares++;
      $display("FAIL quiesce_empty_early: got %b want 0", bus.quiesce_done);
    end
    step();
    vectors++;
    if (bus.quiesce_done !== 1'b1) begin
      miscompares++;
      $display("FAIL quiesce_empty_done: got %b want 1", bus.quiesce_done);
    end
    step();
  endtask

  task automatic test_reset_mid_drain();
    idle_inputs();
    do_reset();
    bus.hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 2'b10; bus.req_pc[1] = 32'h700 + 32'(4 * c); bus.req_taken[1] = 2'b11;
      step();
    end
    vectors++;
    if (bus.count !== CW'(3)) begin
      miscompares++;
      $display("FAIL reset_mid_precount: got %0d want 3", bus.count);
    end
    idle_inputs();
    do_reset();
    vectors++;
    if (bus.count !== '0 || bus.enable_res !== 1'b0 || bus.pc_res !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid: got count=%0d en=%b pc=%h want 0/0/0",
               bus.count, bus.enable_res, bus.pc_res);
    end
    bus.req_valid = 2'b11; bus.req_pc[0] = 32'h800; bus.req_pc[1] = 32'h900;
    step();
    vectors++;
    if (obs_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_mid_tie: got %b want 01", obs_ready);
    end
    bus.req_valid = 2'b00;
    step(); step();
  endtask

  task automatic test_random();
    idle_inputs();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      bus.req_valid    = 2'($urandom);
      bus.req_pc[0]    = $urandom; bus.req_pc[1] = $urandom;
      bus.req_taken[0] = 2'($urandom); bus.req_taken[1] = 2'($urandom);
      bus.hold         = ($urandom_range(0, 3) == 0);
      bus.quiesce_req  = ($urandom_range(0, 19) == 0);
      step();
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_wrap();
    test_quiesce();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
